// File: rtl/pe_grid_pkg.sv
// Shared constants, FSM state type and packed vector type for the PE-grid scheduler.
// The config-legality helper is kept here so the RTL and its users agree on the rule.
package pe_grid_pkg;
  localparam int ROWS      = 12;
  localparam int COLS      = 14;
  localparam int DW        = 16;
  localparam int TAG_W     = 4;
  localparam int LEN_W     = 8;
  localparam int DRAIN_CYC = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } sched_state_e;

  typedef logic [COLS*DW-1:0] wvec_t;

  function automatic logic cfg_legal(input logic [TAG_W-1:0] rows, input logic [LEN_W-1:0] len);
    return (rows != '0) && (rows <= TAG_W'(ROWS)) && (len != '0);
  endfunction
endpackage

// File: rtl/pe_grid_scheduler.sv
// Loads weight rows, streams image vectors, then waits out the psum chain; grid outputs registered (1 cycle).
// Readies decode state only and never overlap; optional stall counter under PE_SCHED_STALL_CNT_EN.
module pe_grid_scheduler
  import pe_grid_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [TAG_W-1:0]   cfg_num_rows,
  input  logic [LEN_W-1:0]   cfg_img_len,
  input  logic               w_valid,
  output logic               w_ready,
  input  wvec_t              w_data,
  input  logic               img_valid,
  output logic               img_ready,
  input  wvec_t              img_data,
  output wvec_t              row_weight_vals,
  output logic [TAG_W-1:0]   tag_row,
  output logic               valid_y,
  output wvec_t              image_val_vec,
  output logic [COLS-1:0]    valid_x_vec,
  output logic               psum_valid,
  output logic               busy,
  output logic               cfg_err,
  output logic [15:0]        stall_cnt
);

  localparam int DRAIN_LOAD = (DRAIN_CYC == 0) ? 1 : DRAIN_CYC;
  localparam int DRAIN_W    = $clog2(DRAIN_LOAD + 1);

  sched_state_e        state;
  logic [TAG_W-1:0]    cfg_rows;
  logic [LEN_W-1:0]    cfg_len;
  logic [TAG_W-1:0]    row_cnt;
  logic [LEN_W-1:0]    beat_cnt;
  logic [DRAIN_W-1:0]  drain_cnt;

  assign w_ready   = (state == LOAD_W);
  assign img_ready = (state == STREAM);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      cfg_rows        <= '0;
      cfg_len         <= '0;
      row_cnt         <= '0;
      beat_cnt        <= '0;
      drain_cnt       <= '0;
      row_weight_vals <= '0;
      tag_row         <= '0;
      valid_y         <= 1'b0;
      image_val_vec   <= '0;
      valid_x_vec     <= '0;
      psum_valid      <= 1'b0;
      cfg_err         <= 1'b0;
    end else begin
      valid_y     <= 1'b0;
      valid_x_vec <= '0;
      psum_valid  <= 1'b0;
      cfg_err     <= 1'b0;
      // Abort beats everything, including a handshake completing this cycle.
      if (abort) begin
        state     <= IDLE;
        row_cnt   <= '0;
        beat_cnt  <= '0;
        drain_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (cfg_legal(cfg_num_rows, cfg_img_len)) begin
                cfg_rows <= cfg_num_rows;
                cfg_len  <= cfg_img_len;
                row_cnt  <= '0;
                beat_cnt <= '0;
                state    <= LOAD_W;
              end else begin
                cfg_err <= 1'b1;
              end
            end
          end
          LOAD_W: begin
            if (w_valid) begin
              row_weight_vals <= w_data;
              tag_row         <= row_cnt;
              valid_y         <= 1'b1;
              row_cnt         <= row_cnt + TAG_W'(1);
              if (row_cnt == cfg_rows - TAG_W'(1)) state <= STREAM;
            end
          end
          STREAM: begin
            if (img_valid) begin
              image_val_vec <= img_data;
              valid_x_vec   <= '1;
              beat_cnt      <= beat_cnt + LEN_W'(1);
              if (beat_cnt == cfg_len - LEN_W'(1)) begin
                state     <= DRAIN;
                drain_cnt <= DRAIN_W'(DRAIN_LOAD);
              end
            end
          end
          DRAIN: begin
            if (drain_cnt == DRAIN_W'(1)) begin
              psum_valid <= 1'b1;
              drain_cnt  <= '0;
              state      <= IDLE;
            end else begin
              drain_cnt <= drain_cnt - DRAIN_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef PE_SCHED_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (state == IDLE && start && !abort && cfg_legal(cfg_num_rows, cfg_img_len)) begin
      stall_cnt <= '0;
    end else if (((state == LOAD_W && !w_valid) || (state == STREAM && !img_valid)) &&
                 stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pe_grid_scheduler.sv
// Randomized bench for pe_grid_scheduler against a pass-level reference model.
module tb_pe_grid_scheduler;
  import pe_grid_pkg::*;

  localparam int DRAIN_EFF = (DRAIN_CYC == 0) ? 1 : DRAIN_CYC;
  localparam int IDLEP = 0, LOADP = 1, STRP = 2, DRNP = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, abort = 1'b0;
  logic [TAG_W-1:0] cfg_num_rows = '0;
  logic [LEN_W-1:0] cfg_img_len = '0;
  logic w_valid = 1'b0, img_valid = 1'b0;
  wvec_t w_data = '0, img_data = '0;
  logic w_ready, img_ready, valid_y, psum_valid, busy, cfg_err;
  wvec_t row_weight_vals, image_val_vec;
  logic [TAG_W-1:0] tag_row;
  logic [COLS-1:0] valid_x_vec;
  logic [15:0] stall_cnt;

  pe_grid_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_num_rows(cfg_num_rows), .cfg_img_len(cfg_img_len),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .img_valid(img_valid), .img_ready(img_ready), .img_data(img_data),
    .row_weight_vals(row_weight_vals), .tag_row(tag_row), .valid_y(valid_y),
    .image_val_vec(image_val_vec), .valid_x_vec(valid_x_vec),
    .psum_valid(psum_valid), .busy(busy), .cfg_err(cfg_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  // Reference model state: pass phase plus progress counts and expected outputs.
  int ph, nrows, nlen, rows_done, beats_done, due, cyc, wcyc, vmode, pct;
  logic exp_vy, exp_vx, exp_psum, exp_err;
  logic [TAG_W-1:0] exp_tag;
  wvec_t exp_w, exp_img;
  logic [15:0] exp_stall;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, want, cyc);
    end
  endtask

  function automatic wvec_t rnd_vec();
    wvec_t v;
    for (int c = 0; c < COLS; c++) v[c*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  task automatic model_reset();
    ph = IDLEP; nrows = 0; nlen = 0; rows_done = 0; beats_done = 0; due = 0; wcyc = 0;
    exp_vy = 0; exp_vx = 0; exp_psum = 0; exp_err = 0;
    exp_tag = '0; exp_w = '0; exp_img = '0; exp_stall = '0;
  endtask

  task automatic check_outs();
    logic [COLS-1:0] vx_want;
    vx_want = exp_vx ? {COLS{1'b1}} : {COLS{1'b0}};
    chk("busy", busy, ph != IDLEP);
    chk("w_ready", w_ready, ph == LOADP);
    chk("img_ready", img_ready, ph == STRP);
    chk("valid_y", valid_y, exp_vy);
    chk("tag_row", tag_row, exp_tag);
    chk("row_weight_vals", row_weight_vals, exp_w);
    chk("valid_x_vec", valid_x_vec, vx_want);
    chk("image_val_vec", image_val_vec, exp_img);
    chk("psum_valid", psum_valid, exp_psum);
    chk("cfg_err", cfg_err, exp_err);
    chk("stall_cnt", stall_cnt, exp_stall);
  endtask

  // One clock cycle: check current outputs, drive inputs, advance model, cross the edge.
  task automatic step(input logic st, input logic ab);
    logic wv, iv;
    wvec_t wd, id;
    int nr, nl;
    check_outs();
    case (vmode)
      0: begin wv = 1'b1; iv = 1'b1; end
      1: begin wv = (ph == LOADP) ? (wcyc % 2 == 0) : 1'b0; iv = 1'b1; end
      default: begin
        wv = ($urandom_range(0, 99) < pct);
        iv = ($urandom_range(0, 99) < pct);
      end
    endcase
    if (ph == LOADP) wcyc++;
    wd = rnd_vec();
    id = rnd_vec();
    start = st; abort = ab; w_valid = wv; w_data = wd; img_valid = iv; img_data = id;

    exp_vy = 0; exp_vx = 0; exp_psum = 0; exp_err = 0;
`ifdef PE_SCHED_STALL_CNT_EN
    if (((ph == LOADP && !wv) || (ph == STRP && !iv)) && exp_stall != 16'hFFFF) exp_stall++;
`endif
    if (ab) begin
      ph = IDLEP;
    end else begin
      case (ph)
        IDLEP: if (st) begin
          nr = int'(cfg_num_rows);
          nl = int'(cfg_img_len);
          if (nr >= 1 && nr <= ROWS && nl >= 1) begin
            ph = LOADP; nrows = nr; nlen = nl; rows_done = 0; beats_done = 0;
            wcyc = 0; exp_stall = '0;
          end else begin
            exp_err = 1;
          end
        end
        LOADP: if (wv) begin
          exp_vy = 1; exp_tag = TAG_W'(rows_done); exp_w = wd; rows_done++;
          if (rows_done == nrows) ph = STRP;
        end
        STRP: if (iv) begin
          exp_vx = 1; exp_img = id; beats_done++;
          if (beats_done == nlen) begin ph = DRNP; due = cyc + 1 + DRAIN_EFF; end
        end
        default: if (cyc + 1 == due) begin exp_psum = 1; ph = IDLEP; end
      endcase
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic start_pass(input int nr, input int nl, input int mode);
    vmode = mode;
    cfg_num_rows = TAG_W'(nr);
    cfg_img_len = LEN_W'(nl);
    step(1'b1, 1'b0);
  endtask

  task automatic finish_pass(input int ab_pm);
    for (int k = 0; k < 3000 && ph != IDLEP; k++) begin
      cfg_num_rows = TAG_W'($urandom);
      cfg_img_len = LEN_W'($urandom);
      step($urandom_range(0, 5) == 0, (ab_pm > 0) && ($urandom_range(0, 999) < ab_pm));
    end
    chk("pass_end_busy", busy, 1'b0);
  endtask

  initial begin
    cyc = 0; vmode = 0; pct = 100;
    model_reset();
    #3;
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid_y", valid_y, 1'b0);
    chk("rst_row_weight_vals", row_weight_vals, '0);
    chk("rst_stall_cnt", stall_cnt, '0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b0);

    // Full pass, sources always valid.
    start_pass(12, 4, 0);
    finish_pass(0);
    repeat (2) step(1'b0, 1'b0);

    // Weight source toggling every other cycle.
    start_pass(12, 4, 1);
    finish_pass(0);
`ifdef PE_SCHED_STALL_CNT_EN
    chk("stall_after_toggle", stall_cnt, 16'd11);
`endif
    step(1'b0, 1'b0);

    // Illegal configurations, then start+abort together in IDLE.
    vmode = 2; pct = 50;
    cfg_num_rows = 4'd0;  cfg_img_len = 8'd4; step(1'b1, 1'b0); step(1'b0, 1'b0);
    cfg_num_rows = 4'd13; cfg_img_len = 8'd4; step(1'b1, 1'b0); step(1'b0, 1'b0);
    cfg_num_rows = 4'd12; cfg_img_len = 8'd0; step(1'b1, 1'b0); step(1'b0, 1'b0);
    cfg_num_rows = 4'd3;  cfg_img_len = 8'd2; step(1'b1, 1'b1); step(1'b0, 1'b0);
    chk("start_abort_idle_busy", busy, 1'b0);

    // Abort during DRAIN with 5 drain cycles left, start in the same cycle.
    start_pass(12, 4, 0);
    for (int k = 0; k < 200 && !(ph == DRNP && due - cyc == 5); k++) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    chk("abort_drain_busy", busy, 1'b0);
    repeat (15) step(1'b0, 1'b0);

    // Extra start pulses while streaming.
    start_pass(3, 6, 0);
    for (int k = 0; k < 100 && ph != STRP; k++) step(1'b0, 1'b0);
    cfg_num_rows = 4'd1; cfg_img_len = 8'd1;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    finish_pass(0);

    // Asynchronous reset mid-stream, then a full pass.
    start_pass(12, 8, 0);
    for (int k = 0; k < 100 && !(ph == STRP && beats_done == 3); k++) step(1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_valid_x_vec", valid_x_vec, '0);
    chk("arst_image_val_vec", image_val_vec, '0);
    chk("arst_row_weight_vals", row_weight_vals, '0);
    chk("arst_tag_row", tag_row, '0);
    chk("arst_img_ready", img_ready, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cyc++;
    step(1'b0, 1'b0);
    start_pass(12, 4, 0);
    finish_pass(0);

    // Longest image length with a single weight row.
    start_pass(1, 255, 0);
    finish_pass(0);

    // Randomized passes with random valid density, stray starts and rare aborts.
    for (int p = 0; p < 25; p++) begin
      pct = $urandom_range(30, 100);
      start_pass($urandom_range(1, ROWS), $urandom_range(1, 16), 2);
      finish_pass(8);
      repeat ($urandom_range(0, 2)) step(1'b0, 1'b0);
    end
    step(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_chk, n_err);
    $fatal(1, "watchdog");
  end

endmodule
